pattern_valid_generator: RTL and testbench



---
 rtl/pattern_valid_generator.sv | 124 ++++++++++++
 tb/tb_pattern_valid_generator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pattern_valid_generator.sv
// Transmit-side valid-lane pattern generator for mainband valid training.
// Sends VALTRAIN words (4 iterations per 32-bit word) in long or short
// bursts under a start/done handshake, with serializer backpressure.
//
// state | meaning
// IDLE  | lane held low, waiting for a start with a legal mode
// SEND  | presenting pattern words, counting accepted words
// DONE  | one-cycle completion pulse, then back to IDLE
module pattern_valid_generator #(
  parameter logic [7:0] VALID_8BIT  = 8'b11110000,
  parameter int         LONG_ITERS  = 128,
  parameter int         SHORT_ITERS = 16,
  parameter int         CNT_W       = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable_128,
  input  logic             i_enable_cons,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_tx_ready,
  output logic [31:0]      o_tvld_l,
  output logic             o_tvld_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_mode_err,
  output logic [CNT_W-1:0] o_word_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [31:0]      PATTERN   = {4{VALID_8BIT}};
  localparam logic [CNT_W-1:0] LONG_TGT  = CNT_W'(LONG_ITERS / 4);
  localparam logic [CNT_W-1:0] SHORT_TGT = CNT_W'(SHORT_ITERS / 4);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      tvld_d;
  logic             valid_d, busy_d, done_d, err_d;
  logic             mode_legal;
  logic [CNT_W-1:0] mode_tgt;
  logic             accept;
  logic             last_word;

  // Only one-hot enable combinations select a burst length.
  assign mode_legal = i_enable_128 ^ i_enable_cons;
  assign mode_tgt   = i_enable_128 ? LONG_TGT : SHORT_TGT;
  assign accept     = o_tvld_valid && i_tx_ready;
  // Pre-increment compare keeps the counter from ever passing the target.
  assign last_word  = (o_word_cnt == target_q - CNT_W'(1));

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = o_word_cnt;
    tvld_d   = '0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          if (mode_legal) begin
            state_d  = SEND;
            target_d = mode_tgt;
            cnt_d    = '0;
            tvld_d   = PATTERN;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (accept && last_word) begin
          state_d = DONE;
          cnt_d   = target_q;
          done_d  = 1'b1;
        end else begin
          if (accept) cnt_d = o_word_cnt + CNT_W'(1);
          tvld_d  = PATTERN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched target and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      o_word_cnt   <= '0;
      o_tvld_l     <= '0;
      o_tvld_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_mode_err   <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      o_word_cnt   <= cnt_d;
      o_tvld_l     <= tvld_d;
      o_tvld_valid <= valid_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_mode_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_pattern_valid_generator.sv
// Self-checking bench for pattern_valid_generator: expected outputs are
// queued as each cycle's stimulus is driven and compared one cycle later.
module tb_pattern_valid_generator;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_enable_128;
  logic        i_enable_cons;
  logic        i_start;
  logic        i_abort;
  logic        i_tx_ready;
  logic [31:0] o_tvld_l;
  logic        o_tvld_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_mode_err;
  logic [5:0]  o_word_cnt;

  localparam logic [31:0] PAT = 32'hF0F0F0F0;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          m_cnt        = 0;
  logic [41:0] exp_q[$];

  pattern_valid_generator dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_enable_128 (i_enable_128),
    .i_enable_cons(i_enable_cons),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_tx_ready   (i_tx_ready),
    .o_tvld_l     (o_tvld_l),
    .o_tvld_valid (o_tvld_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_mode_err   (o_mode_err),
    .o_word_cnt   (o_word_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [41:0] obs_vec();
    return {o_tvld_l, o_tvld_valid, o_busy, o_done, o_mode_err, o_word_cnt};
  endfunction

  // phase: 0 idle, 1 sending, 2 done
  function automatic logic [41:0] exp_vec(input int phase, input logic err, input int cnt);
    case (phase)
      1:       return {PAT, 1'b1, 1'b1, 1'b0, 1'b0, 6'(cnt)};
      2:       return {32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'(cnt)};
      default: return {32'h0, 1'b0, 1'b0, 1'b0, err, 6'(cnt)};
    endcase
  endfunction

  task automatic run_burst(input string tag, input logic cons, input logic e128,
                           input int tgt, input int ncyc, input int lo_from, input int lo_to,
                           input int abort_at, input bit toggle, input bit spam, input int rst_at,
                           input int exp_done, input int exp_err, input int exp_cnt);
    int   phase;
    int   done_cyc;
    int   err_cyc;
    logic legal;
    logic st, ab, rd, err;
    phase    = 0;
    done_cyc = -1;
    err_cyc  = -1;
    legal    = cons ^ e128;
    for (int c = 0; c < ncyc; c++) begin
      if (exp_q.size() > 0) check({tag, "_out"}, obs_vec(), exp_q.pop_front());
      if (o_done) done_cyc = c;
      if (o_mode_err) err_cyc = c;
      if (c == rst_at) begin
        i_rst_n = 1'b0;
        #1;
        check({tag, "_rst_async"}, obs_vec(), 42'h0);
        i_start = 1'b0;
        i_abort = 1'b0;
        @(posedge i_clk);
        #1;
        check({tag, "_rst_hold"}, obs_vec(), 42'h0);
        i_rst_n = 1'b1;
        m_cnt   = 0;
        exp_q.delete();
        break;
      end
      st = (c == 0) || (spam && phase != 0);
      ab = (c == abort_at);
      rd = !(c >= lo_from && c <= lo_to);
      i_start       = st;
      i_abort       = ab;
      i_tx_ready    = rd;
      i_enable_128  = e128;
      i_enable_cons = (toggle && c > 0) ? (cons ^ (c % 2 == 1)) : cons;
      err = 1'b0;
      case (phase)
        0: if (st && !ab) begin
             if (legal) begin
               phase = 1;
               m_cnt = 0;
             end else begin
               err = 1'b1;
             end
           end
        1: if (ab) phase = 0;
           else if (rd) begin
             m_cnt++;
             if (m_cnt == tgt) phase = 2;
           end
        default: phase = 0;
      endcase
      exp_q.push_back(exp_vec(phase, err, m_cnt));
      @(posedge i_clk);
      #1;
    end
    i_start    = 1'b0;
    i_abort    = 1'b0;
    i_tx_ready = 1'b1;
    if (exp_q.size() > 0) begin
      check({tag, "_out"}, obs_vec(), exp_q.pop_front());
      if (o_done) done_cyc = ncyc;
      if (o_mode_err) err_cyc = ncyc;
    end
    check({tag, "_done_cycle"}, 42'(done_cyc), 42'(exp_done));
    check({tag, "_err_cycle"}, 42'(err_cyc), 42'(exp_err));
    check({tag, "_final_cnt"}, 42'(o_word_cnt), 42'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n       = 1'b0;
    i_enable_128  = 1'b0;
    i_enable_cons = 1'b0;
    i_start       = 1'b0;
    i_abort       = 1'b0;
    i_tx_ready    = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_vals", obs_vec(), 42'h0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("after_reset", obs_vec(), 42'h0);

    //        tag          cons  128  tgt ncyc lo  lo  abort tog spam rst done err cnt
    run_burst("long",      1'b0, 1'b1, 32, 35, -1, -1, -1,   0,  0,  -1,  33, -1, 32);
    run_burst("short_tog", 1'b1, 1'b0,  4,  7, -1, -1, -1,   1,  0,  -1,   5, -1,  4);
    run_burst("ready_lo",  1'b0, 1'b1, 32, 40,  5,  9, -1,   0,  0,  -1,  38, -1, 32);
    run_burst("abort3",    1'b1, 1'b0,  4,  6, -1, -1,  3,   0,  0,  -1,  -1, -1,  2);
    run_burst("abort_fin", 1'b1, 1'b0,  4,  7, -1, -1,  4,   0,  0,  -1,  -1, -1,  3);
    run_burst("mode11",    1'b1, 1'b1,  4,  3, -1, -1, -1,   0,  0,  -1,  -1,  1,  3);
    run_burst("mode00",    1'b0, 1'b0,  4,  3, -1, -1, -1,   0,  0,  -1,  -1,  1,  3);
    run_burst("st_abort",  1'b0, 1'b1, 32,  3, -1, -1,  0,   0,  0,  -1,  -1, -1,  3);
    run_burst("spam",      1'b1, 1'b0,  4,  8, -1, -1, -1,   0,  1,  -1,   5, -1,  4);
    run_burst("rst_mid",   1'b0, 1'b1, 32, 20, -1, -1, -1,   0,  0,  10,  -1, -1,  0);
    run_burst("fresh",     1'b0, 1'b1, 32, 35, -1, -1, -1,   0,  0,  -1,  33, -1, 32);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
